// File: rtl/intt_scheduler_if.sv
// Descriptor issue / completion channel between the inverse-NTT scheduler and the
// butterfly datapath; the scheduler holds a descriptor until op_ready takes it.
interface intt_scheduler_if #(
  parameter int AW = 8
);
  logic          op_valid;
  logic          op_ready;
  logic          op_scale;
  logic [AW-1:0] op_addr_a;
  logic [AW-1:0] op_addr_b;
  logic [AW-2:0] op_zeta_idx;
  logic [2:0]    op_layer;
  logic          cmp_valid;

  modport master (
    output op_valid, op_scale, op_addr_a, op_addr_b, op_zeta_idx, op_layer,
    input  op_ready, cmp_valid
  );

  modport slave (
    input  op_valid, op_scale, op_addr_a, op_addr_b, op_zeta_idx, op_layer,
    output op_ready, cmp_valid
  );
endinterface

// File: rtl/intt_scheduler.sv
// Inverse-NTT op sequencer: one descriptor per cycle on op_ready, layers separated by a drain
// until every issued op has completed, then N scale ops; op_valid goes high the cycle after start.
module intt_scheduler #(
  parameter int N  = 256,
  parameter int AW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [AW:0]      outstanding,
  output logic             err_underflow,
  intt_scheduler_if.master op_if
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ISSUE_BF = 3'd1,
    S_DRAIN_BF = 3'd2,
    S_ISSUE_SC = 3'd3,
    S_DRAIN_SC = 3'd4,
    S_DONE     = 3'd5
  } state_e;

  localparam logic [AW:0]   ONE_W      = 1;
  localparam logic [AW:0]   N_W        = N;
  localparam logic [AW-2:0] ZETA_INIT  = (AW-1)'(N/2 - 1);
  localparam logic [2:0]    LAST_LAYER = 3'(AW - 2);

  state_e        state_q, state_d;
  logic [2:0]    layer_q, layer_d;
  logic [AW-1:0] addr_q,  addr_d;
  logic [AW-2:0] zeta_q,  zeta_d;
  logic [AW:0]   outst_q, outst_d;
  logic          err_q,   err_d;

  logic          issue;
  logic          fire;
  logic [AW:0]   len_w;
  logic [AW:0]   addr_ext;
  logic [AW:0]   nxt_a;
  logic          blk_end;
  logic          layer_end;

  assign issue    = (state_q == S_ISSUE_BF) || (state_q == S_ISSUE_SC);
  assign fire     = issue && op_if.op_ready;
  assign len_w    = ONE_W << (layer_q + 3'd1);
  assign addr_ext = {1'b0, addr_q};
  assign nxt_a    = addr_ext + 1'b1;
  // Blocks start on multiples of 2*len, so the low half ends when j+1 clears the offset bits.
  assign blk_end   = ((nxt_a & (len_w - 1'b1)) == '0);
  assign layer_end = blk_end && ((nxt_a + len_w) == N_W);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      layer_q <= '0;
      addr_q  <= '0;
      zeta_q  <= '0;
      outst_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      addr_q  <= addr_d;
      zeta_q  <= zeta_d;
      outst_q <= outst_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    addr_d  = addr_q;
    zeta_d  = zeta_q;
    outst_d = outst_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ISSUE_BF;
          layer_d = '0;
          addr_d  = '0;
          zeta_d  = ZETA_INIT;
        end
      end
      S_ISSUE_BF: begin
        if (fire) begin
          if (blk_end) begin
            addr_d = AW'(nxt_a + len_w);
            zeta_d = zeta_q - 1'b1;
          end else begin
            addr_d = AW'(nxt_a);
          end
          if (layer_end) begin
            addr_d  = '0;
            state_d = S_DRAIN_BF;
          end
        end
      end
      S_DRAIN_BF: begin
        if (outst_q == '0) begin
          if (layer_q == LAST_LAYER) begin
            state_d = S_ISSUE_SC;
          end else begin
            layer_d = layer_q + 3'd1;
            state_d = S_ISSUE_BF;
          end
        end
      end
      S_ISSUE_SC: begin
        if (fire) begin
          addr_d = AW'(nxt_a);
          if (nxt_a == N_W) state_d = S_DRAIN_SC;
        end
      end
      S_DRAIN_SC: begin
        if (outst_q == '0) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A completion with nothing in flight is a datapath fault: flag it and keep the count at zero.
    if (fire && !op_if.cmp_valid) begin
      outst_d = outst_q + 1'b1;
    end else if (!fire && op_if.cmp_valid) begin
      if (outst_q == '0) err_d = 1'b1;
      else               outst_d = outst_q - 1'b1;
    end
  end

  always_comb begin
    op_if.op_valid    = 1'b0;
    op_if.op_scale    = 1'b0;
    op_if.op_addr_a   = '0;
    op_if.op_addr_b   = '0;
    op_if.op_zeta_idx = '0;
    op_if.op_layer    = '0;
    busy              = (state_q != S_IDLE);
    done              = (state_q == S_DONE);
    outstanding       = outst_q;
    err_underflow     = err_q;

    case (state_q)
      S_ISSUE_BF: begin
        op_if.op_valid    = 1'b1;
        op_if.op_addr_a   = addr_q;
        op_if.op_addr_b   = AW'(addr_ext + len_w);
        op_if.op_zeta_idx = zeta_q;
        op_if.op_layer    = layer_q;
      end
      S_ISSUE_SC: begin
        op_if.op_valid  = 1'b1;
        op_if.op_scale  = 1'b1;
        op_if.op_addr_a = addr_q;
      end
      default: ;
    endcase
  end

endmodule
